mem_block_server: RTL and testbench



---
 rtl/mem_block_server.sv | 157 +++++++++++++++
 tb/tb_mem_block_server.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_server.sv
// mem_block_server
//   Backing memory behind the direct-mapped cache. It serves block refills
//   and dirty write-backs. Each request waits out a programmable latency and
//   then holds a four-phase, level-held handshake.
//
//   Ports
//     clk             clock, all state on the rising edge
//     rst             asynchronous, active-low reset
//     read_en_mem     refill request, held until valid_mem is seen
//     write_en_mem    write-back request, held until ready_mem is seen
//     address         word address; low OFFSET_WIDTH bits and tag bits above
//                     the index are ignored (index wraps modulo MEM_DEPTH)
//     dirty_block_out evicted block for write-back
//     data_out_mem    refill data, registered, holds its last value
//     valid_mem       refill data valid (level)
//     ready_mem       write-back committed (level)
//
//   Optional build macro MEM_PERF_CNT_EN adds rd_count / wr_count, which count
//   completed refills and write-backs.
module mem_block_server #(
    parameter int BLOCK_SIZE    = 128,
    parameter int ADDR_WIDTH    = 32,
    parameter int OFFSET_WIDTH  = 2,
    parameter int MEM_DEPTH     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en_mem,
    input  logic                  write_en_mem,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [BLOCK_SIZE-1:0] dirty_block_out,
    output logic [BLOCK_SIZE-1:0] data_out_mem,
    output logic                  valid_mem,
    output logic                  ready_mem
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    // The counter is loaded with LATENCY-1, so MAX_LAT-1 is the largest value.
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_ACK
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [BLOCK_SIZE-1:0] wdata;
    logic [BLOCK_SIZE-1:0] mem [MEM_DEPTH];

    logic [IDX_W-1:0]      req_idx;
    logic                  commit;
    logic                  rd_done;
    logic                  unused_addr;

    assign req_idx     = address[OFFSET_WIDTH +: IDX_W];
    assign commit      = (state == WR_WAIT) && (cnt == '0);
    assign rd_done     = (state == RD_WAIT) && (cnt == '0);
    // The offset and tag bits of the address play no part in indexing.
    assign unused_addr = ^address;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            wdata        <= '0;
            data_out_mem <= '0;
            valid_mem    <= 1'b0;
            ready_mem    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A write wins over a simultaneous read, so the eviction
                    // lands before the refill of the same line.
                    if (write_en_mem) begin
                        idx   <= req_idx;
                        wdata <= dirty_block_out;
                        cnt   <= CNT_W'(WRITE_LATENCY - 1);
                        state <= WR_WAIT;
                    end else if (read_en_mem) begin
                        idx   <= req_idx;
                        cnt   <= CNT_W'(READ_LATENCY - 1);
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        data_out_mem <= mem[idx];
                        valid_mem    <= 1'b1;
                        state        <= RD_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RD_RESP: begin
                    if (!read_en_mem) begin
                        valid_mem <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        ready_mem <= 1'b1;
                        state     <= WR_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WR_ACK: begin
                    if (!write_en_mem) begin
                        ready_mem <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset. Reset forces the FSM out of WR_WAIT
    // asynchronously, so a write that has not reached its commit edge is
    // dropped.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[idx] <= wdata;
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done) rd_count <= rd_count + 32'd1;
            if (commit)  wr_count <= wr_count + 32'd1;
        end
    end
`else
    logic unused_done;
    assign unused_done = rd_done;
`endif

endmodule

// File: tb/tb_mem_block_server.sv
module tb_mem_block_server;
    localparam int RL = 4;
    localparam int WL = 2;
    localparam int TMO = 40;

    logic         clk;
    logic         rst;
    logic         read_en_mem;
    logic         write_en_mem;
    logic [31:0]  address;
    logic [127:0] dirty_block_out;
    logic [127:0] data_out_mem;
    logic         valid_mem;
    logic         ready_mem;
`ifdef MEM_PERF_CNT_EN
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
`endif

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_wr  = 0;
    logic [127:0] mem_m [int];

    mem_block_server dut (
        .clk             (clk),
        .rst             (rst),
        .read_en_mem     (read_en_mem),
        .write_en_mem    (write_en_mem),
        .address         (address),
        .dirty_block_out (dirty_block_out),
        .data_out_mem    (data_out_mem),
        .valid_mem       (valid_mem),
        .ready_mem       (ready_mem)
`ifdef MEM_PERF_CNT_EN
        ,
        .rd_count        (rd_count),
        .wr_count        (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 32'd1024);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Counts edges after the accepting edge until the flag rises.
    task automatic wait_flag(input bit want_rd, input bit scramble, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            chk("excl", 128'(valid_mem & ready_mem), 128'd0);
            if (scramble) begin
                address         = $urandom();
                dirty_block_out = rnd128();
            end
        end while (!(want_rd ? valid_mem : ready_mem) && n < TMO);
    endtask

    task automatic do_read(input logic [31:0] a, input bit early);
        int n;
        int i;
        i = idx_of(a);
        @(negedge clk);
        read_en_mem = 1'b1;
        address     = a;
        @(posedge clk);
        if (early) begin
            @(negedge clk);
            read_en_mem = 1'b0;
            address     = $urandom();
        end
        wait_flag(1'b1, 1'b0, n);
        chk("rd_lat", 128'(n), 128'(RL));
        if (valid_mem) n_rd++;
        if (mem_m.exists(i)) chk("rd_data", data_out_mem, mem_m[i]);
        if (early) begin
            @(posedge clk); #1;
            chk("rd_pulse", 128'(valid_mem), 128'd0);
        end else begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                chk("rd_hold", 128'(valid_mem), 128'd1);
                if (mem_m.exists(i)) chk("rd_stable", data_out_mem, mem_m[i]);
            end
            @(negedge clk);
            read_en_mem = 1'b0;
            @(posedge clk); #1;
            chk("rd_drop", 128'(valid_mem), 128'd0);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d, input bit scramble);
        int n;
        @(negedge clk);
        write_en_mem    = 1'b1;
        address         = a;
        dirty_block_out = d;
        @(posedge clk);
        wait_flag(1'b0, scramble, n);
        chk("wr_lat", 128'(n), 128'(WL));
        if (ready_mem) begin
            mem_m[idx_of(a)] = d;
            n_wr++;
        end
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk("wr_hold", 128'(ready_mem), 128'd1);
        end
        @(negedge clk);
        write_en_mem = 1'b0;
        @(posedge clk); #1;
        chk("wr_drop", 128'(ready_mem), 128'd0);
    endtask

    // Both enables rise together: the write is served first, then the read,
    // which is still held, is accepted from IDLE.
    task automatic do_both(input logic [31:0] a, input logic [127:0] d);
        int n;
        @(negedge clk);
        read_en_mem     = 1'b1;
        write_en_mem    = 1'b1;
        address         = a;
        dirty_block_out = d;
        @(posedge clk);
        wait_flag(1'b0, 1'b0, n);
        chk("both_wr_lat", 128'(n), 128'(WL));
        chk("both_no_valid", 128'(valid_mem), 128'd0);
        if (ready_mem) begin
            mem_m[idx_of(a)] = d;
            n_wr++;
        end
        @(negedge clk);
        write_en_mem = 1'b0;
        @(posedge clk); #1;
        chk("both_release", 128'(ready_mem | valid_mem), 128'd0);
        @(posedge clk);
        wait_flag(1'b1, 1'b0, n);
        chk("both_rd_lat", 128'(n), 128'(RL));
        chk("both_rd_data", data_out_mem, d);
        if (valid_mem) n_rd++;
        @(negedge clk);
        read_en_mem = 1'b0;
        @(posedge clk); #1;
        chk("both_rd_drop", 128'(valid_mem), 128'd0);
    endtask

    task automatic check_counts(input string tag);
`ifdef MEM_PERF_CNT_EN
        chk({tag, "_rd_count"}, 128'(rd_count), 128'(n_rd));
        chk({tag, "_wr_count"}, 128'(wr_count), 128'(n_wr));
`else
        if (tag.len() == 0) $display("no counters");
`endif
    endtask

    initial begin
        logic [31:0]  a;
        logic [127:0] d;
        rst             = 1'b1;
        read_en_mem     = 1'b0;
        write_en_mem    = 1'b0;
        address         = '0;
        dirty_block_out = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 128'(valid_mem), 128'd0);
        chk("rst_ready", 128'(ready_mem), 128'd0);
        chk("rst_data", data_out_mem, 128'd0);
        check_counts("rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Known block at index 3, then refill it.
        do_write(32'h0000_000C, 128'hCAFEBABE_8899AABB_44556677_DDEEFF00, 1'b0);
        do_read(32'h0000_000C, 1'b0);
        // Tag bits above the index alias to the same block.
        do_read(32'h0000_100C, 1'b0);

        do_write(32'h2AAAAA08, 128'hFEEDFACE_77665544_33445566_CCDDEEFF, 1'b0);
        do_read(32'h2AAAAA08, 1'b0);

        do_both(32'h0D5E6F02, rnd128());

        // Inputs scrambled during the wait; the latched values are written.
        do_write(32'h0000_0040, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b1);
        do_read(32'h0000_0040, 1'b0);

        // Reset before the commit edge: the block keeps its old contents.
        @(negedge clk);
        write_en_mem    = 1'b1;
        address         = 32'h0000_000C;
        dirty_block_out = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_rd = 0;
        n_wr = 0;
        chk("mid_rst_valid", 128'(valid_mem), 128'd0);
        chk("mid_rst_ready", 128'(ready_mem), 128'd0);
        chk("mid_rst_data", data_out_mem, 128'd0);
        check_counts("mid_rst");
        write_en_mem = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_read(32'h0000_000C, 1'b0);

        // A request dropped during the wait still completes as a pulse.
        do_read(32'h2AAAAA08, 1'b1);

        for (int k = 0; k < 25; k++) begin
            a = $urandom();
            a[11:2] = 10'($urandom_range(0, 7));
            d = rnd128();
            case ($urandom_range(0, 4))
                0:       do_write(a, d, 1'b0);
                1:       do_write(a, d, 1'b1);
                2:       do_read(a, 1'b0);
                3:       do_read(a, 1'b1);
                default: do_both(a, d);
            endcase
        end

        check_counts("end");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
